// File: rtl/apb_master_arbiter.sv
// APB master shared by two requesters: round-robin arbitration, one transfer in
// flight, and an ACCESS-phase timeout that ends a stalled transfer as an error.
module apb_master_arbiter #(
  parameter int APB_ADDR_WIDTH = 12,
  parameter int APB_DATA_WIDTH = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                      clk_i,
  input  logic                      rst_i,

  input  logic                      req0_valid_i,
  output logic                      req0_ready_o,
  input  logic [APB_ADDR_WIDTH-1:0] req0_addr_i,
  input  logic                      req0_write_i,
  input  logic [APB_DATA_WIDTH-1:0] req0_wdata_i,
  output logic                      rsp0_valid_o,
  output logic [APB_DATA_WIDTH-1:0] rsp0_rdata_o,
  output logic                      rsp0_err_o,

  input  logic                      req1_valid_i,
  output logic                      req1_ready_o,
  input  logic [APB_ADDR_WIDTH-1:0] req1_addr_i,
  input  logic                      req1_write_i,
  input  logic [APB_DATA_WIDTH-1:0] req1_wdata_i,
  output logic                      rsp1_valid_o,
  output logic [APB_DATA_WIDTH-1:0] rsp1_rdata_o,
  output logic                      rsp1_err_o,

  output logic [APB_ADDR_WIDTH-1:0] paddr_o,
  output logic                      psel_o,
  output logic                      penable_o,
  output logic                      pwrite_o,
  output logic [APB_DATA_WIDTH-1:0] pwdata_o,
  input  logic [APB_DATA_WIDTH-1:0] prdata_i,
  input  logic                      pready_i,
  input  logic                      pslverr_i
);

  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t                    state_reg, state_next;
  logic                      ptr_reg, ptr_next;
  logic                      owner_reg, owner_next;
  logic [7:0]                cnt_reg, cnt_next;
  logic [APB_ADDR_WIDTH-1:0] addr_reg, addr_next;
  logic                      write_reg, write_next;
  logic [APB_DATA_WIDTH-1:0] wdata_reg, wdata_next;

  logic [1:0]                req_valid;
  logic [1:0]                req_write;
  logic [APB_ADDR_WIDTH-1:0] req_addr [2];
  logic [APB_DATA_WIDTH-1:0] req_wdata [2];
  logic [1:0]                grant;
  logic                      winner;
  logic                      done;
  logic [APB_DATA_WIDTH-1:0] done_rdata;
  logic                      done_err;

  assign req_valid    = {req1_valid_i, req0_valid_i};
  assign req_write    = {req1_write_i, req0_write_i};
  assign req_addr[0]  = req0_addr_i;
  assign req_addr[1]  = req1_addr_i;
  assign req_wdata[0] = req0_wdata_i;
  assign req_wdata[1] = req1_wdata_i;

  // With both requesters pending the pointer decides; a lone requester always wins.
  assign winner = (&req_valid) ? ptr_reg : req_valid[1];

  always_comb begin
    state_next = state_reg;
    ptr_next   = ptr_reg;
    owner_next = owner_reg;
    cnt_next   = cnt_reg;
    addr_next  = addr_reg;
    write_next = write_reg;
    wdata_next = wdata_reg;
    grant      = 2'b00;
    done       = 1'b0;
    done_rdata = '0;
    done_err   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (|req_valid) begin
          grant[winner] = 1'b1;
          owner_next    = winner;
          ptr_next      = ~winner;
          addr_next     = req_addr[winner];
          write_next    = req_write[winner];
          wdata_next    = req_wdata[winner];
          cnt_next      = '0;
          state_next    = SETUP;
        end
      end
      SETUP: state_next = ACCESS;
      ACCESS: begin
        // A slave response in the final allowed cycle still completes normally.
        if (pready_i) begin
          done       = 1'b1;
          done_rdata = write_reg ? '0 : prdata_i;
          done_err   = pslverr_i;
          state_next = IDLE;
        end else if (cnt_reg == TIMEOUT_LAST) begin
          done       = 1'b1;
          done_err   = 1'b1;
          cnt_next   = cnt_reg + 8'd1;
          state_next = IDLE;
        end else begin
          cnt_next = cnt_reg + 8'd1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg <= IDLE;
      ptr_reg   <= 1'b0;
      owner_reg <= 1'b0;
      cnt_reg   <= '0;
      addr_reg  <= '0;
      write_reg <= 1'b0;
      wdata_reg <= '0;
    end else begin
      state_reg <= state_next;
      ptr_reg   <= ptr_next;
      owner_reg <= owner_next;
      cnt_reg   <= cnt_next;
      addr_reg  <= addr_next;
      write_reg <= write_next;
      wdata_reg <= wdata_next;
    end
  end

  // Each requester keeps its own response registers so idle ports hold their last result.
  for (genvar gi = 0; gi < 2; gi++) begin : g_rsp
    logic                      valid_reg;
    logic [APB_DATA_WIDTH-1:0] rdata_reg;
    logic                      err_reg;
    logic                      mine;

    assign mine = done && (owner_reg == 1'(gi));

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        valid_reg <= 1'b0;
        rdata_reg <= '0;
        err_reg   <= 1'b0;
      end else begin
        valid_reg <= mine;
        if (mine) begin
          rdata_reg <= done_rdata;
          err_reg   <= done_err;
        end
      end
    end
  end

  assign req0_ready_o = grant[0];
  assign req1_ready_o = grant[1];
  assign rsp0_valid_o = g_rsp[0].valid_reg;
  assign rsp0_rdata_o = g_rsp[0].rdata_reg;
  assign rsp0_err_o   = g_rsp[0].err_reg;
  assign rsp1_valid_o = g_rsp[1].valid_reg;
  assign rsp1_rdata_o = g_rsp[1].rdata_reg;
  assign rsp1_err_o   = g_rsp[1].err_reg;

  assign paddr_o   = addr_reg;
  assign pwrite_o  = write_reg;
  assign pwdata_o  = wdata_reg;
  assign psel_o    = (state_reg != IDLE);
  assign penable_o = (state_reg == ACCESS);

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Bench for apb_master_arbiter: directed scenarios then randomized traffic, every
// cycle compared against a transaction-schedule model of the arbiter and APB timing.
module tb_apb_master_arbiter;
  localparam int AW = 12;
  localparam int DW = 32;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rst_i = 1'b1;
  logic          req0_valid_i = 1'b0, req1_valid_i = 1'b0;
  logic          req0_ready_o, req1_ready_o;
  logic [AW-1:0] req0_addr_i = '0, req1_addr_i = '0;
  logic          req0_write_i = 1'b0, req1_write_i = 1'b0;
  logic [DW-1:0] req0_wdata_i = '0, req1_wdata_i = '0;
  logic          rsp0_valid_o, rsp1_valid_o;
  logic [DW-1:0] rsp0_rdata_o, rsp1_rdata_o;
  logic          rsp0_err_o, rsp1_err_o;
  logic [AW-1:0] paddr_o;
  logic          psel_o, penable_o, pwrite_o;
  logic [DW-1:0] pwdata_o;
  logic [DW-1:0] prdata_i = '0;
  logic          pready_i = 1'b0, pslverr_i = 1'b0;

  apb_master_arbiter #(.APB_ADDR_WIDTH(AW), .APB_DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .req0_valid_i(req0_valid_i), .req0_ready_o(req0_ready_o), .req0_addr_i(req0_addr_i),
    .req0_write_i(req0_write_i), .req0_wdata_i(req0_wdata_i),
    .rsp0_valid_o(rsp0_valid_o), .rsp0_rdata_o(rsp0_rdata_o), .rsp0_err_o(rsp0_err_o),
    .req1_valid_i(req1_valid_i), .req1_ready_o(req1_ready_o), .req1_addr_i(req1_addr_i),
    .req1_write_i(req1_write_i), .req1_wdata_i(req1_wdata_i),
    .rsp1_valid_o(rsp1_valid_o), .rsp1_rdata_o(rsp1_rdata_o), .rsp1_err_o(rsp1_err_o),
    .paddr_o(paddr_o), .psel_o(psel_o), .penable_o(penable_o), .pwrite_o(pwrite_o),
    .pwdata_o(pwdata_o), .prdata_i(prdata_i), .pready_i(pready_i), .pslverr_i(pslverr_i)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Stimulus requested by the scenario code
  logic [1:0]    want_valid = 2'b00;
  logic [AW-1:0] want_addr [2];
  logic          want_write [2];
  logic [DW-1:0] want_wdata [2];
  bit            rst_req = 1'b1;
  int            next_wait = 0;
  bit            dir_en = 1'b0;
  logic [DW-1:0] dir_rdata = '0;
  bit            dir_err = 1'b0;
  bit            got [2];
  int            dut_rsp_q [$];

  // Model: the pending transfer is described by its accept cycle and ACCESS length
  bit            m_busy, m_ptr, m_owner, m_write, m_to;
  int            m_acc, m_len;
  logic [AW-1:0] m_paddr;
  logic [DW-1:0] m_pwdata;
  bit            m_pwrite;
  logic [DW-1:0] m_txn_rdata;
  bit            m_txn_err;
  logic [DW-1:0] m_last_rdata [2];
  bit            m_last_err [2];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h cycle=%0d", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_busy = 1'b0; m_ptr = 1'b0; m_owner = 1'b0; m_write = 1'b0; m_to = 1'b0;
    m_acc = 0; m_len = 0;
    m_paddr = '0; m_pwdata = '0; m_pwrite = 1'b0;
    m_txn_rdata = '0; m_txn_err = 1'b0;
    for (int n = 0; n < 2; n++) begin
      m_last_rdata[n] = '0;
      m_last_err[n]   = 1'b0;
    end
  endtask

  // One clock cycle: compare registered outputs, drive slave and requesters, check grant.
  task automatic step();
    bit       rst_prev;
    int       phase;
    bit [1:0] exp_rv;
    bit [1:0] exp_rdy;
    bit       winner;
    @(posedge clk);
    #2;
    cyc++;
    rst_prev = rst_i;
    exp_rv = 2'b00;
    if (rst_prev) begin
      model_reset();
    end else if (m_busy && (cyc - m_acc) == m_len + 2) begin
      m_busy = 1'b0;
      exp_rv[m_owner] = 1'b1;
      m_last_rdata[m_owner] = (!m_write && !m_to) ? m_txn_rdata : '0;
      m_last_err[m_owner]   = m_to ? 1'b1 : m_txn_err;
    end
    phase = cyc - m_acc;
    check("psel", psel_o, m_busy);
    check("penable", penable_o, m_busy && phase >= 2);
    check("paddr", paddr_o, m_paddr);
    check("pwrite", pwrite_o, m_pwrite);
    check("pwdata", pwdata_o, m_pwdata);
    check("rsp0_valid", rsp0_valid_o, exp_rv[0]);
    check("rsp1_valid", rsp1_valid_o, exp_rv[1]);
    check("rsp0_rdata", rsp0_rdata_o, m_last_rdata[0]);
    check("rsp1_rdata", rsp1_rdata_o, m_last_rdata[1]);
    check("rsp0_err", rsp0_err_o, m_last_err[0]);
    check("rsp1_err", rsp1_err_o, m_last_err[1]);
    if (rsp0_valid_o === 1'b1) dut_rsp_q.push_back(0);
    if (rsp1_valid_o === 1'b1) dut_rsp_q.push_back(1);

    if (m_busy && phase >= 2) begin
      pready_i  = !m_to && (phase == m_len + 1);
      prdata_i  = pready_i ? m_txn_rdata : $urandom;
      pslverr_i = pready_i ? m_txn_err : 1'($urandom);
    end else begin
      // Slave noise outside ACCESS must have no effect
      pready_i  = 1'($urandom);
      pslverr_i = 1'($urandom);
      prdata_i  = $urandom;
    end

    req0_valid_i = want_valid[0];
    req0_addr_i  = want_addr[0];
    req0_write_i = want_write[0];
    req0_wdata_i = want_wdata[0];
    req1_valid_i = want_valid[1];
    req1_addr_i  = want_addr[1];
    req1_write_i = want_write[1];
    req1_wdata_i = want_wdata[1];
    rst_i        = rst_req;
    #1;

    exp_rdy = 2'b00;
    winner  = 1'b0;
    if (!m_busy && want_valid != 2'b00) begin
      winner = (want_valid == 2'b11) ? m_ptr : want_valid[1];
      exp_rdy[winner] = 1'b1;
    end
    check("req0_ready", req0_ready_o, exp_rdy[0]);
    check("req1_ready", req1_ready_o, exp_rdy[1]);
    if (exp_rdy != 2'b00 && !rst_req) begin
      m_ptr       = ~winner;
      m_busy      = 1'b1;
      m_acc       = cyc;
      m_owner     = winner;
      m_write     = want_write[winner];
      m_paddr     = want_addr[winner];
      m_pwrite    = want_write[winner];
      m_pwdata    = want_wdata[winner];
      m_to        = (next_wait >= TO);
      m_len       = m_to ? TO : next_wait + 1;
      m_txn_rdata = dir_en ? dir_rdata : $urandom;
      m_txn_err   = dir_en ? dir_err : 1'($urandom);
      got[winner] = 1'b1;
    end
  endtask

  task automatic do_reset();
    rst_req = 1'b1;
    step();
    rst_req = 1'b0;
    step();
  endtask

  initial begin
    int  acc_cycles;
    bit  seen;
    for (int n = 0; n < 2; n++) begin
      want_addr[n] = '0; want_write[n] = 1'b0; want_wdata[n] = '0; got[n] = 1'b0;
    end
    model_reset();

    // Power-on reset
    rst_req = 1'b1;
    step();
    step();
    rst_req = 1'b0;
    step();
    check("reset_paddr", paddr_o, 0);
    check("reset_psel", psel_o, 0);
    check("reset_rsp0_err", rsp0_err_o, 0);

    // Single zero-wait read from requester 0
    want_valid = 2'b01; want_addr[0] = 12'h010; want_write[0] = 1'b0;
    next_wait = 0; dir_en = 1'b1; dir_rdata = 32'hDEADBEEF; dir_err = 1'b0;
    step();
    check("a_ready0_T", req0_ready_o, 1);
    want_valid = 2'b00;
    step();
    check("a_psel_T1", psel_o, 1);
    check("a_penable_T1", penable_o, 0);
    check("a_paddr_T1", paddr_o, 12'h010);
    step();
    check("a_penable_T2", penable_o, 1);
    step();
    check("a_rsp0_valid_T3", rsp0_valid_o, 1);
    check("a_rsp0_rdata_T3", rsp0_rdata_o, 32'hDEADBEEF);
    check("a_rsp0_err_T3", rsp0_err_o, 0);
    check("a_rsp1_valid_T3", rsp1_valid_o, 0);

    // Both requesters permanently valid from reset: strict alternation
    do_reset();
    dut_rsp_q.delete();
    dir_en = 1'b0; next_wait = 0;
    want_valid = 2'b11;
    for (int n = 0; n < 2; n++) begin
      want_addr[n] = AW'($urandom); want_write[n] = 1'b0; want_wdata[n] = $urandom;
    end
    repeat (13) step();
    want_valid = 2'b00;
    repeat (4) step();
    check("b_rsp_count_ge4", dut_rsp_q.size() >= 4, 1);
    for (int i = 0; i < 4 && i < dut_rsp_q.size(); i++)
      check($sformatf("b_grant_order_%0d", i), dut_rsp_q[i], i % 2);

    // Write from requester 1 with three wait states and a slave error
    want_valid = 2'b10; want_addr[1] = 12'h004; want_write[1] = 1'b1; want_wdata[1] = 32'h12345678;
    next_wait = 3; dir_en = 1'b1; dir_rdata = 32'hCAFEF00D; dir_err = 1'b1;
    step();
    want_valid = 2'b00;
    for (int i = 0; i < 5; i++) begin
      step();
      check("c_psel", psel_o, 1);
      check("c_paddr_stable", paddr_o, 12'h004);
      check("c_pwdata_stable", pwdata_o, 32'h12345678);
    end
    step();
    check("c_rsp1_valid", rsp1_valid_o, 1);
    check("c_rsp1_err", rsp1_err_o, 1);
    check("c_rsp1_rdata", rsp1_rdata_o, 0);
    check("c_rsp0_valid", rsp0_valid_o, 0);

    // Read that the slave never answers: timeout
    want_valid = 2'b01; want_addr[0] = 12'h020; want_write[0] = 1'b0;
    next_wait = 1000; dir_en = 1'b0;
    step();
    want_valid = 2'b00;
    acc_cycles = 0;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      step();
      if (penable_o === 1'b1) acc_cycles++;
      if (rsp0_valid_o === 1'b1) seen = 1'b1;
    end
    check("d_rsp_seen", seen, 1);
    check("d_access_cycles", acc_cycles, TO);
    check("d_rsp0_err", rsp0_err_o, 1);
    check("d_rsp0_rdata", rsp0_rdata_o, 0);
    check("d_idle_psel", psel_o, 0);

    // Reset pulse in the middle of ACCESS
    want_valid = 2'b01; want_addr[0] = 12'h030; want_write[0] = 1'b0; next_wait = 5;
    step();
    want_valid = 2'b00;
    step();
    rst_req = 1'b1;
    step();
    check("e_in_access", penable_o, 1);
    rst_req = 1'b0;
    step();
    check("e_psel_after_reset", psel_o, 0);
    for (int i = 0; i < 10; i++) begin
      step();
      check("e_no_rsp0", rsp0_valid_o, 0);
    end
    want_valid = 2'b11;
    step();
    check("e_ptr_ready0", req0_ready_o, 1);
    check("e_ptr_ready1", req1_ready_o, 0);
    want_valid = 2'b00;
    repeat (4) step();

    // Randomized traffic with occasional resets and timeouts
    dir_en = 1'b0;
    got[0] = 1'b0; got[1] = 1'b0;
    for (int i = 0; i < 600; i++) begin
      for (int n = 0; n < 2; n++) begin
        if (!want_valid[n] || got[n]) begin
          got[n]        = 1'b0;
          want_valid[n] = ($urandom_range(0, 2) != 0);
          want_addr[n]  = AW'($urandom);
          want_write[n] = 1'($urandom);
          want_wdata[n] = $urandom;
        end
      end
      next_wait = ($urandom_range(0, 9) == 0) ? int'($urandom_range(16, 25)) : int'($urandom_range(0, 5));
      rst_req   = ($urandom_range(0, 149) == 0);
      step();
    end
    rst_req = 1'b0;
    want_valid = 2'b00;
    repeat (30) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/apb_master_arbiter.md
APB_MASTER_ARBITER -- requirements
Module: apb_master_arbiter

Interface
REQ-001 SHALL have parameter APB_ADDR_WIDTH, default 12, APB address width.
REQ-002 SHALL have parameter APB_DATA_WIDTH, default 32, APB data width.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 16, maximum ACCESS-phase cycles before forced error (legal range 1..255).
REQ-004 SHALL have ports: clk_i in 1, sole clock, all logic on rising edge; rst_i in 1, synchronous active-high reset.
REQ-005 SHALL have, per requester n in {0,1}: req<n>_valid_i in 1, request pending; req<n>_ready_o out 1, request accepted.
REQ-006 SHALL have, per requester: req<n>_addr_i in APB_ADDR_WIDTH; req<n>_write_i in 1 (1=write); req<n>_wdata_i in APB_DATA_WIDTH.
REQ-007 SHALL have, per requester: rsp<n>_valid_o out 1, one-cycle completion pulse; rsp<n>_rdata_o out APB_DATA_WIDTH; rsp<n>_err_o out 1.
REQ-008 SHALL have APB master ports: paddr_o out APB_ADDR_WIDTH; psel_o out 1; penable_o out 1; pwrite_o out 1; pwdata_o out APB_DATA_WIDTH.
REQ-009 SHALL have APB inputs: prdata_i in APB_DATA_WIDTH; pready_i in 1; pslverr_i in 1.

Function
REQ-010 SHALL implement FSM states IDLE, SETUP, ACCESS; one APB transfer in flight at most.
REQ-011 In IDLE, SHALL assert req<n>_ready_o combinationally for exactly one valid requester (the arbitration winner); ready_o SHALL be 0 in SETUP/ACCESS and for the loser.
REQ-012 Arbitration SHALL be round-robin: a one-bit priority pointer favours requester 0 after reset; when both are valid the favoured one wins; after any grant the pointer moves to the other requester.
REQ-013 When only one requester is valid it SHALL win regardless of pointer; pointer still toggles to the other.
REQ-014 On accept (valid & ready), SHALL register addr/write/wdata and the owner index, and move IDLE->SETUP.
REQ-015 In SETUP: psel_o=1, penable_o=0; unconditionally move to ACCESS next cycle.
REQ-016 In ACCESS: psel_o=1, penable_o=1; stay until pready_i=1 or timeout.
REQ-017 paddr_o, pwrite_o, pwdata_o SHALL remain constant from SETUP through the last ACCESS cycle; in IDLE they hold last values; psel_o=penable_o=0 in IDLE.
REQ-018 An 8-bit counter SHALL clear on SETUP entry and increment each ACCESS cycle with pready_i=0; when it reaches TIMEOUT_CYCLES the transfer SHALL terminate as error.
REQ-019 On completion (pready_i=1 in ACCESS, or timeout), SHALL register a response: rsp<owner>_valid_o=1 for exactly the next cycle; FSM returns to IDLE that same next cycle.
REQ-020 Response data: read with pready -> rdata=prdata_i, err=pslverr_i; write -> rdata=0, err=pslverr_i; timeout -> rdata=0, err=1.
REQ-021 Non-owner rsp_valid_o SHALL stay 0; rsp_rdata_o/rsp_err_o hold last values when rsp_valid_o=0.
REQ-022 Latency: accept at cycle T, zero-wait slave -> SETUP T+1, ACCESS T+2, rsp_valid_o at T+3; next accept possible at T+3.
REQ-023 pready_i and pslverr_i SHALL be ignored outside ACCESS.
REQ-024 Requests SHALL never be dropped: a valid not granted remains eligible; no response pulse without a prior accept.

Reset
REQ-025 On rst_i=1 at a clock edge: state=IDLE, pointer=requester 0, counter=0, psel_o=penable_o=pwrite_o=0, paddr_o=0, pwdata_o=0, all rsp<n>_valid_o/err_o=0, rdata=0.
REQ-026 Reset asserted mid-transfer SHALL abort it: psel_o=0 the next cycle, no response pulse issued for the aborted request.

Verification
REQ-027 Single read, req0 addr=0x010, slave pready=1 first ACCESS cycle, prdata=0xDEADBEEF -> psel at T+1, penable at T+2, rsp0_valid at T+3 with rdata=0xDEADBEEF, err=0.
REQ-028 Both valid every cycle from reset, zero-wait slave -> grant order 0,1,0,1; each rsp pulse on the matching port only.
REQ-029 Write req1 addr=0x004 wdata=0x12345678, slave holds pready=0 for 3 ACCESS cycles then pready=1 with pslverr=1 -> paddr/pwdata stable throughout, rsp1_valid with err=1, rdata=0.
REQ-030 Read with pready never asserted, TIMEOUT_CYCLES=16 -> exactly 16 ACCESS cycles, then rsp_valid with err=1, rdata=0, FSM IDLE.
REQ-031 rst_i pulsed during ACCESS of a req0 read -> psel_o=0 next cycle, no rsp0_valid pulse, pointer back to requester 0.
